weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 120 ++++++++++++
 tb/tb_weight_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : weight_loader
//  Function : Checksummed byte-stream loader for hidden-neuron weights; a
//             frame is staged in a shadow register and committed atomically.
//  Revision : 1.0 - initial release
// ============================================================================
module weight_loader #(
    parameter int N_NEURONS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [7:0]                data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [N_NEURONS*32-1:0]   weights_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int c_nbytes = N_NEURONS * 4;
    localparam int c_cw     = $clog2(c_nbytes + 1);
    localparam int c_ww     = N_NEURONS * 32;
    localparam logic [c_cw-1:0] c_last_idx = c_cw'(c_nbytes - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [c_ww-1:0]   shadow_q, shadow_d;
    logic [c_ww-1:0]   weights_q, weights_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              w_xfer;

    assign ready_o   = (state_q != IDLE);
    assign busy_o    = (state_q != IDLE);
    assign w_xfer    = valid_i & ready_o;
    assign weights_o = weights_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sum_q     <= '0;
            shadow_q  <= '0;
            weights_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            shadow_q  <= shadow_d;
            weights_q <= weights_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        shadow_d  = shadow_q;
        weights_d = weights_q;
        done_d    = 1'b0;
        err_d     = err_q;

        // load_i wins over any byte transferred in the same cycle
        if (load_i) begin
            state_d  = LOAD;
            cnt_d    = '0;
            sum_d    = '0;
            shadow_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (w_xfer) begin
                        for (int b = 0; b < c_nbytes; b++) begin
                            if (int'(cnt_q) == b) begin
                                shadow_d[b*8 +: 8] = data_i;
                            end
                        end
                        sum_d = sum_q + data_i;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == c_last_idx) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_xfer) begin
                        state_d = IDLE;
                        if (data_i == sum_q) begin
                            weights_d = shadow_q;
                            done_d    = 1'b1;
                        end else begin
                            err_d     = 1'b1;
                        end
                    end
                end
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_loader
//  Function : Self-checking bench for weight_loader (N_NEURONS = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

    localparam int N  = 2;
    localparam int NB = N * 4;
    localparam int WW = N * 32;

    logic          clk;
    logic          rst;
    logic          load;
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic [WW-1:0] weights;
    logic          busy;
    logic          done;
    logic          err;

    int            checks;
    int            failures;
    logic [WW-1:0] model_w;
    logic [7:0]    fb [NB];

    weight_loader #(.N_NEURONS(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready),
        .weights_o (weights),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: frame bytes laid out little-end-first, checksum = byte sum mod 256
    function automatic logic [WW-1:0] pack_frame();
        logic [WW-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v[k*8 +: 8] = fb[k];
        return v;
    endfunction

    function automatic logic [7:0] frame_sum();
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) s = s + int'(fb[k]);
        return 8'(s % 256);
    endfunction

    task automatic pulse_load();
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            valid = 1'b0;
            data  = 8'($urandom);
            @(posedge clk); #1;
        end
        valid = 1'b1;
        data  = b;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cks, input int maxgap);
        for (int k = 0; k < NB; k++) send_byte(fb[k], $urandom_range(0, maxgap));
        send_byte(cks, $urandom_range(0, maxgap));
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 1'b0; valid = 1'b0; data = 8'h00;
        #2;
        checks++;
        if ({ready, busy, done, err} !== 4'b0000 || weights !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b err=%b w=%h expected all zero",
                     ready, busy, done, err, weights);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_w = '0;
    endtask

    task automatic test_no_load();
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1;
            data  = 8'($urandom);
            #1;
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL no_load_ready: got rdy=%b busy=%b expected 0 0", ready, busy);
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        checks++;
        if (weights !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL no_load_weights: got w=%h done=%b expected 0 0", weights, done);
        end
    endtask

    task automatic test_good_frame();
        pulse_load();
        checks++;
        if (busy !== 1'b1 || ready !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL good_start: got busy=%b rdy=%b err=%b expected 1 1 0", busy, ready, err);
        end
        for (int k = 0; k < NB; k++) begin
            send_byte(8'h10 + 8'(k), 0);
            checks++;
            if (weights !== '0 || done !== 1'b0) begin
                failures++;
                $display("FAIL good_partial: got w=%h done=%b expected 0 0", weights, done);
            end
        end
        send_byte(8'h9C, 0);
        model_w = 64'h1716151413121110;
        checks++;
        if (weights !== model_w || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL good_commit: got w=%h done=%b err=%b busy=%b expected w=%h 1 0 0",
                     weights, done, err, busy, model_w);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL good_done_width: got done=%b expected 0", done);
        end
    endtask

    task automatic test_bad_checksum();
        for (int k = 0; k < NB; k++) fb[k] = 8'h10 + 8'(k);
        pulse_load();
        for (int k = 0; k < NB; k++) send_byte(fb[k], 0);
        send_byte(8'h00, 0);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || weights !== model_w || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_cks: got err=%b done=%b w=%h busy=%b expected 1 0 w=%h 0",
                     err, done, weights, busy, model_w);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL bad_cks_sticky: got err=%b done=%b expected 1 0", err, done);
        end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < NB; k++) fb[k] = 8'h10 + 8'(k);
        model_w = '0;
        weights_clear_check: begin
            // commit an unrelated frame first so the gapped frame must visibly change weights_o
            for (int k = 0; k < NB; k++) fb[k] = 8'hA0 + 8'(k);
            pulse_load();
            send_frame(frame_sum(), 0);
            model_w = pack_frame();
        end
        for (int k = 0; k < NB; k++) fb[k] = 8'h10 + 8'(k);
        pulse_load();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL gaps_err_clear: got err=%b expected 0", err);
        end
        send_frame(8'h9C, 5);
        model_w = 64'h1716151413121110;
        checks++;
        if (weights !== model_w || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gaps_commit: got w=%h done=%b err=%b busy=%b expected w=%h 1 0 0",
                     weights, done, err, busy, model_w);
        end
    endtask

    task automatic test_restart();
        pulse_load();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 0);
        // restart with a byte offered in the same cycle; that byte must be dropped
        load  = 1'b1;
        valid = 1'b1;
        data  = 8'hFF;
        @(posedge clk); #1;
        load  = 1'b0;
        valid = 1'b0;
        for (int k = 0; k < NB; k++) fb[k] = 8'(k + 1);
        send_frame(8'h24, 0);
        model_w = 64'h0807060504030201;
        checks++;
        if (weights !== model_w || done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL restart_commit: got w=%h done=%b err=%b expected w=%h 1 0",
                     weights, done, err, model_w);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) begin
            logic       good;
            logic [7:0] cks;
            for (int k = 0; k < NB; k++) fb[k] = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            cks  = good ? frame_sum() : (frame_sum() ^ 8'($urandom_range(1, 255)));
            pulse_load();
            send_frame(cks, 3);
            if (good) model_w = pack_frame();
            checks++;
            if (weights !== model_w || done !== good || err !== !good || busy !== 1'b0) begin
                failures++;
                $display("FAIL random_frame%0d: got w=%h done=%b err=%b busy=%b expected w=%h %b %b 0",
                         f, weights, done, err, busy, model_w, good, !good);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midframe();
        pulse_load();
        for (int k = 0; k < 5; k++) send_byte(8'h30 + 8'(k), 0);
        rst = 1'b0;
        #1;
        model_w = '0;
        checks++;
        if ({ready, busy, done, err} !== 4'b0000 || weights !== model_w) begin
            failures++;
            $display("FAIL midframe_reset: got rdy=%b busy=%b done=%b err=%b w=%h expected all zero",
                     ready, busy, done, err, weights);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < NB + 1; k++) begin
            send_byte(8'($urandom), 0);
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0 || weights !== model_w || done !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_ignore: got rdy=%b busy=%b w=%h done=%b expected 0 0 0 0",
                         ready, busy, weights, done);
            end
        end
        for (int k = 0; k < NB; k++) fb[k] = 8'h50 + 8'(k);
        pulse_load();
        send_frame(frame_sum(), 2);
        model_w = pack_frame();
        checks++;
        if (weights !== model_w || done !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_frame: got w=%h done=%b expected w=%h 1", weights, done, model_w);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_no_load();
        test_good_frame();
        test_bad_checksum();
        test_gaps();
        test_restart();
        test_random_frames();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
